gbt_frameclk_en_gen: RTL and testbench
======================================

// Module: gbt_frameclk_en_gen
// PURPOSE
//  Parametrised frame-clock enable generator for the GBT TX path, successor to the fixed 120->40 MHz frame-clock PLL.
//  Runs on the PLL reference clock; emits a 1-cycle frame strobe every DIV cycles with selectable phase.
//  Qualifies the PLL lock input before enabling the strobe; flags and recovers from loss of lock (LOL).
//  Output frame_en_o gates frame-rate logic directly in the refclk domain, with no extra clock net.
// PARAMETERS
//  DIV          3     refclk cycles per frame strobe, >=2
//  LOCK_CYCLES  1024  consecutive synced-locked cycles required before RUN, >=1
//  SYNC_STAGES  2     pll_locked_i synchroniser depth, >=2
//  PH_W         derived = max(1,$clog2(DIV)), not overridable
// PORTS
//  refclk        in   1     sole clock
//  rst           in   1     synchronous, active-high reset
//  pll_locked_i  in   1     PLL locked, asynchronous to refclk
//  phase_sel_i   in   PH_W  strobe phase within frame; values >=DIV treated as 0
//  align_i       in   1     1-cycle pulse, restarts frame counter (RUN only)
//  lol_clr_i     in   1     clears lol_sticky_o
//  frame_en_o    out  1     frame strobe, 1 cycle wide, period DIV
//  ready_o       out  1     high while in RUN
//  lol_sticky_o  out  1     set on any LOL while in RUN
//  lol_count_o   out  8     LOL event count (macro-dependent, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, synchroniser flops 0, state WAIT_LOCK, div_cnt=0, lock_cnt=0, phase_q=0.
//  - Synchroniser: pll_locked_i -> SYNC_STAGES flops -> lk_s; latency SYNC_STAGES edges.
//  - FSM (registered):
//    WAIT_LOCK: lk_s=1 -> SETTLE with lock_cnt=0.
//    SETTLE: lk_s=0 -> WAIT_LOCK (count discarded); otherwise lock_cnt++;
//            when lock_cnt==LOCK_CYCLES-1 with lk_s=1 -> RUN, div_cnt=0, phase_q=phase_sel_i.
//    RUN: lk_s=0 -> WAIT_LOCK and LOL event (lol_sticky_o set, counter incremented).
//  - ready_o is registered: high exactly in cycles where state==RUN.
//  - div_cnt counts 0..DIV-1 and wraps to 0; it counts only in RUN.
//  - frame_en_o is registered from (state==RUN && div_cnt==phase_q): high one cycle after the match.
//  - frame_en_o is 0 in every cycle where ready_o is 0.
//  - align_i sampled in RUN: div_cnt=0 and phase_q=phase_sel_i next cycle; ignored outside RUN.
//  - align_i coinciding with the wrap: align wins. No strobe is emitted in the cycle after the align edge unless the pre-align div_cnt matched.
//  - phase_sel_i is sampled only on RUN entry and on align_i; changes at other times have no effect.
//  - LOL and lol_clr_i in the same cycle: set wins (sticky stays 1).
//  - rst mid-RUN: next cycle all outputs 0, state WAIT_LOCK; reset is not counted as LOL.
// CONFIGURATION
//  FRAMECLK_LOL_COUNT_EN defined:
//   - lol_count_o is an 8-bit counter, +1 per LOL event, saturates at 255.
//   - Cleared by rst and by lol_clr_i; a simultaneous LOL event wins, giving 1.
//  FRAMECLK_LOL_COUNT_EN undefined: lol_count_o tied to 8'd0, no counter logic.
// TESTING (DIV=3, LOCK_CYCLES=16, SYNC_STAGES=2 unless noted)
//  1. rst=1 for 4 cycles with pll_locked_i=1 -> frame_en_o, ready_o, lol_sticky_o and lol_count_o all 0 throughout.
//  2. pll_locked_i rises at edge 0 after reset:
//     - ready_o rises at edge SYNC_STAGES+LOCK_CYCLES+1 (=19), not before.
//     - frame_en_o then pulses every 3 cycles.
//  3. pll_locked_i low for 1 cycle at SETTLE lock_cnt=10:
//     - FSM returns to WAIT_LOCK and the lock count restarts.
//     - ready_o rises 19 edges after locked returns.
//     - lol_sticky_o stays 0.
//  4. RUN, phase_sel_i=2, align_i at edge t -> frame_en_o high in cycles t+3, t+6, t+9, and 0 elsewhere.
//     Repeat with phase_sel_i=3 -> phase 0 behaviour: pulses at t+1, t+4, t+7.
//  5. RUN, pll_locked_i drops:
//     - within SYNC_STAGES+1 edges ready_o=0, frame_en_o=0, lol_sticky_o=1.
//     - lol_clr_i in the same cycle as a second LOL -> lol_sticky_o stays 1.
//     - lol_clr_i alone -> lol_sticky_o 0 next cycle.
//  6. With FRAMECLK_LOL_COUNT_EN, 300 LOL events -> lol_count_o=255; lol_clr_i -> 0.
//     Without the macro -> lol_count_o=0 throughout.

Source files
------------

// File: rtl/gbt_frameclk_en_gen.sv
// Frame-clock enable generator: lock-qualified, phase-selectable 1-of-DIV strobe in the refclk domain.
// Optional LOL event counter is enabled by defining FRAMECLK_LOL_COUNT_EN.
module gbt_frameclk_en_gen #(
  parameter int DIV         = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int PH_W       = ($clog2(DIV) > 1) ? $clog2(DIV) : 1
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            pll_locked_i,
  input  logic [PH_W-1:0] phase_sel_i,
  input  logic            align_i,
  input  logic            lol_clr_i,
  output logic            frame_en_o,
  output logic            ready_o,
  output logic            lol_sticky_o,
  output logic [7:0]      lol_count_o
);

  localparam int LC_W = ($clog2(LOCK_CYCLES) > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [PH_W-1:0] DIV_LAST  = PH_W'(DIV - 1);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic [LC_W-1:0]        lock_cnt;
  logic [PH_W-1:0]        div_cnt;
  logic [PH_W-1:0]        phase_q;
  logic [PH_W-1:0]        phase_eff;
  logic                   lol_event;
  logic                   match;

  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign lk_s      = sync_q[SYNC_STAGES-1];
  assign phase_eff = (32'(phase_sel_i) >= DIV) ? '0 : phase_sel_i;
  assign lol_event = (state == RUN) && !lk_s;
  // Gated by lk_s so the strobe never survives into the first not-ready cycle.
  assign match     = (state == RUN) && lk_s && (div_cnt == phase_q);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= WAIT_LOCK;
      lock_cnt     <= '0;
      div_cnt      <= '0;
      phase_q      <= '0;
      ready_o      <= 1'b0;
      frame_en_o   <= 1'b0;
      lol_sticky_o <= 1'b0;
    end else begin
      frame_en_o <= match;
      if (lol_event)      lol_sticky_o <= 1'b1;
      else if (lol_clr_i) lol_sticky_o <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          ready_o <= 1'b0;
          if (lk_s) begin
            state    <= SETTLE;
            lock_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!lk_s) begin
            state <= WAIT_LOCK;
          end else if (lock_cnt == LOCK_LAST) begin
            state   <= RUN;
            ready_o <= 1'b1;
            div_cnt <= '0;
            phase_q <= phase_eff;
          end else begin
            lock_cnt <= lock_cnt + LC_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state   <= WAIT_LOCK;
            ready_o <= 1'b0;
          end else if (align_i) begin
            div_cnt <= '0;
            phase_q <= phase_eff;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + PH_W'(1);
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAMECLK_LOL_COUNT_EN
  logic [7:0] lol_cnt;

  always_ff @(posedge refclk) begin
    if (rst)
      lol_cnt <= 8'd0;
    else if (lol_event)
      lol_cnt <= lol_clr_i ? 8'd1 : ((lol_cnt == 8'hFF) ? lol_cnt : lol_cnt + 8'd1);
    else if (lol_clr_i)
      lol_cnt <= 8'd0;
  end

  assign lol_count_o = lol_cnt;
`else
  assign lol_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_gbt_frameclk_en_gen.sv
// Directed bench for gbt_frameclk_en_gen (DIV=3, LOCK_CYCLES=16, SYNC_STAGES=2).
module tb_gbt_frameclk_en_gen;
  localparam int DIV = 3, LOCK_CYCLES = 16, SYNC_STAGES = 2, PH_W = 2;
`ifdef FRAMECLK_LOL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            refclk = 1'b0;
  logic            rst = 1'b1;
  logic            pll_locked_i = 1'b0;
  logic [PH_W-1:0] phase_sel_i = '0;
  logic            align_i = 1'b0;
  logic            lol_clr_i = 1'b0;
  logic            frame_en_o, ready_o, lol_sticky_o;
  logic [7:0]      lol_count_o;
  int              n_checks = 0;
  int              n_err = 0;

  always #5 refclk = ~refclk;

  gbt_frameclk_en_gen #(.DIV(DIV), .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .refclk(refclk), .rst(rst), .pll_locked_i(pll_locked_i), .phase_sel_i(phase_sel_i),
    .align_i(align_i), .lol_clr_i(lol_clr_i), .frame_en_o(frame_en_o), .ready_o(ready_o),
    .lol_sticky_o(lol_sticky_o), .lol_count_o(lol_count_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int n);
    return CNT_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic chk_out(input string tag, input logic fr, input logic rd, input logic st,
                         input logic [7:0] cnt);
    chk({tag, "_frame"}, frame_en_o, fr);
    chk({tag, "_ready"}, ready_o, rd);
    chk({tag, "_sticky"}, lol_sticky_o, st);
    chk({tag, "_count"}, lol_count_o, cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    // Reset held with the PLL reporting lock: everything stays quiet.
    rst = 1'b1;
    pll_locked_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    pll_locked_i = 1'b0;
    tick();
    // Edge 0: release reset and raise lock.
    rst = 1'b0;
    pll_locked_i = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk("acq_ready_low", ready_o, 0);
      chk("acq_frame_low", frame_en_o, 0);
    end
    tick();
    chk("acq_ready_19", ready_o, 1);
    chk("acq_frame_19", frame_en_o, 0);
    for (int e = 20; e <= 28; e++) begin
      tick();
      chk("run_frame", frame_en_o, ((e - 20) % 3 == 0) ? 1 : 0);
    end

    // Align right after a strobe so the pre-align counter does not match.
    w = 0;
    while (frame_en_o !== 1'b1 && w < 6) begin
      tick();
      w++;
    end
    chk("align_sync", frame_en_o, 1);
    phase_sel_i = 2'd2;
    align_i = 1'b1;
    tick();
    align_i = 1'b0;
    phase_sel_i = 2'd1;
    chk("align2_edge", frame_en_o, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("align2_frame", frame_en_o, (k % 3 == 0) ? 1 : 0);
    end
    phase_sel_i = 2'd3;
    align_i = 1'b1;
    tick();
    align_i = 1'b0;
    phase_sel_i = 2'd2;
    chk("align3_edge", frame_en_o, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("align3_frame", frame_en_o, (k % 3 == 1) ? 1 : 0);
    end
    chk("align3_ready", ready_o, 1);

    // Reset mid-RUN, not counted as a loss of lock.
    rst = 1'b1;
    phase_sel_i = 2'd0;
    tick();
    chk_out("rst_run", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    // One-cycle lock glitch while SETTLE holds lock_cnt=10.
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk("glitch_pre", ready_o, 0);
    end
    pll_locked_i = 1'b0;
    tick();
    chk("glitch_low", ready_o, 0);
    pll_locked_i = 1'b1;
    for (int e = 13; e <= 30; e++) begin
      tick();
      chk("glitch_ready", ready_o, 0);
      chk("glitch_sticky", lol_sticky_o, 0);
    end
    tick();
    chk("glitch_ready_31", ready_o, 1);
    chk("glitch_sticky_31", lol_sticky_o, 0);

    // Loss of lock lands on an edge where the counter matches the phase.
    tick(4);
    pll_locked_i = 1'b0;
    tick(2);
    chk("lol_ready_hold", ready_o, 1);
    chk("lol_sticky_hold", lol_sticky_o, 0);
    tick();
    chk_out("lol1", 1'b0, 1'b0, 1'b1, cnt_exp(1));
    pll_locked_i = 1'b1;
    tick(19);
    chk("relock_ready", ready_o, 1);
    pll_locked_i = 1'b0;
    tick(2);
    lol_clr_i = 1'b1;
    tick();
    lol_clr_i = 1'b0;
    chk_out("lol2_clr", 1'b0, 1'b0, 1'b1, cnt_exp(1));
    tick();
    lol_clr_i = 1'b1;
    tick();
    lol_clr_i = 1'b0;
    chk("clr_sticky", lol_sticky_o, 0);
    chk("clr_count", lol_count_o, 0);

    // Counter saturation over 300 LOL events.
    pll_locked_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(19);
      if (i == 0) chk("sat_run", ready_o, 1);
      pll_locked_i = 1'b0;
      tick(3);
      pll_locked_i = 1'b1;
      if (i == 253) chk("sat_254", lol_count_o, cnt_exp(254));
      if (i == 254) chk("sat_255", lol_count_o, cnt_exp(255));
    end
    chk("sat_final", lol_count_o, cnt_exp(255));
    chk("sat_sticky", lol_sticky_o, 1);
    lol_clr_i = 1'b1;
    tick();
    lol_clr_i = 1'b0;
    chk("sat_clr_count", lol_count_o, 0);
    chk("sat_clr_sticky", lol_sticky_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
